// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store initiator: byte-serial loads and sized stores on the data-memory port
// Optional misaligned-access trap is enabled by defining DMEM_LSU_MISALIGN_TRAP_EN.
module dmem_lsu #(
    parameter int  DATA_WIDTH  = 64,
    parameter int  FETCH_WIDTH = 64,
    localparam int SW          = $clog2(FETCH_WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [DATA_WIDTH-1:0]  req_addr_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_signed_i,
    input  logic [FETCH_WIDTH-1:0] req_wdata_i,
    output logic                   resp_valid_o,
    output logic [FETCH_WIDTH-1:0] resp_rdata_o,
    output logic                   resp_err_o,
    output logic                   dmem_rd_en_o,
    output logic                   dmem_wr_en_o,
    output logic [DATA_WIDTH-1:0]  dmem_addr_o,
    output logic [SW-1:0]          dmem_wr_size_o,
    output logic [FETCH_WIDTH-1:0] dmem_wr_data_o,
    input  logic                   dmem_busy_i,
    input  logic                   dmem_rdy_i,
    input  logic [FETCH_WIDTH-1:0] dmem_rd_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        WAIT_RD,
        ISSUE_WR,
        WAIT_WR,
        RESP
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  base_q;
    logic [1:0]             size_q;
    logic                   signed_q;
    logic [FETCH_WIDTH-1:0] wdata_q;
    logic [SW-1:0]          idx_q;
    logic [FETCH_WIDTH-1:0] asm_q;
    logic [FETCH_WIDTH-1:0] asm_next;
    logic [SW-1:0]          n_m1;
    logic                   resp_valid_q;
    logic [FETCH_WIDTH-1:0] resp_rdata_q;
    logic                   resp_err_q;
    logic                   unused_rd_bits;

    // Only the low byte of each read beat carries data.
    assign unused_rd_bits = ^dmem_rd_data_i[FETCH_WIDTH-1:8];

    assign n_m1 = SW'((4'd1 << size_q) - 4'd1);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    logic [SW-1:0] req_mask;
    logic          req_misaligned;
    assign req_mask       = SW'((4'd1 << req_size_i) - 4'd1);
    assign req_misaligned = |(req_addr_i[SW-1:0] & req_mask);
`endif

    always_comb begin
        asm_next = asm_q;
        asm_next[8*idx_q +: 8] = dmem_rd_data_i[7:0];
    end

    function automatic logic [FETCH_WIDTH-1:0] extend(input logic [FETCH_WIDTH-1:0] d,
                                                      input logic [1:0] sz, input logic sgn);
        case (sz)
            2'd0:    extend = {{(FETCH_WIDTH-8){sgn & d[7]}}, d[7:0]};
            2'd1:    extend = {{(FETCH_WIDTH-16){sgn & d[15]}}, d[15:0]};
            2'd2:    extend = {{(FETCH_WIDTH-32){sgn & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base_q       <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        base_q   <= req_addr_i;
                        size_q   <= req_size_i;
                        signed_q <= req_signed_i;
                        wdata_q  <= req_wdata_i;
                        idx_q    <= '0;
                        asm_q    <= '0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
                        if (req_misaligned) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end else
`endif
                        if (req_we_i) state <= ISSUE_WR;
                        else          state <= ISSUE_RD;
                    end
                end
                ISSUE_RD: if (!dmem_busy_i) state <= WAIT_RD;
                WAIT_RD: begin
                    if (dmem_rdy_i) begin
                        asm_q <= asm_next;
                        if (idx_q == n_m1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= extend(asm_next, size_q, signed_q);
                            resp_err_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_q + SW'(1);
                            state <= ISSUE_RD;
                        end
                    end
                end
                ISSUE_WR: if (!dmem_busy_i) state <= WAIT_WR;
                WAIT_WR: begin
                    if (dmem_rdy_i) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE) && !rst;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign resp_err_o   = resp_err_q;
`else
    assign resp_err_o   = 1'b0;
    logic unused_err;
    assign unused_err   = resp_err_q;
`endif

    // Requests never overlap a busy memory; address and data are zero outside issue states.
    assign dmem_rd_en_o   = (state == ISSUE_RD) && !dmem_busy_i && !rst;
    assign dmem_wr_en_o   = (state == ISSUE_WR) && !dmem_busy_i && !rst;
    assign dmem_addr_o    = (state == ISSUE_RD) ? base_q + DATA_WIDTH'(idx_q) :
                            (state == ISSUE_WR) ? base_q : '0;
    assign dmem_wr_size_o = (state == ISSUE_WR) ? n_m1 : '0;
    assign dmem_wr_data_o = (state == ISSUE_WR) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with a behavioural memory and reference model
module tb_dmem_lsu;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_signed_i;
    logic [63:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        resp_valid_o, resp_err_o;
    logic [63:0] resp_rdata_o;
    logic        dmem_rd_en_o, dmem_wr_en_o;
    logic [63:0] dmem_addr_o, dmem_wr_data_o, dmem_rd_data_i;
    logic [2:0]  dmem_wr_size_o;
    logic        dmem_busy_i, dmem_rdy_i;

    dmem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
        .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o), .dmem_rd_en_o(dmem_rd_en_o), .dmem_wr_en_o(dmem_wr_en_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wr_size_o(dmem_wr_size_o),
        .dmem_wr_data_o(dmem_wr_data_o), .dmem_busy_i(dmem_busy_i), .dmem_rdy_i(dmem_rdy_i),
        .dmem_rd_data_i(dmem_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  mem     [logic [63:0]];
    logic [7:0]  ref_mem [logic [63:0]];
    logic [63:0] rd_log[$];
    int          wr_cnt;
    logic [2:0]  last_wr_size;
    int          fb_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: busy the cycle after a request (1 cycle for reads, N for writes), then a 1-cycle rdy.
    initial begin
        logic        s_rst, s_rd, s_wr, op_rd;
        logic [63:0] s_addr, s_data, op_addr, op_data;
        logic [2:0]  s_size, op_size;
        int          bcnt;
        bcnt = 0; op_rd = 0; op_addr = 0; op_data = 0; op_size = 0;
        dmem_busy_i = 0; dmem_rdy_i = 0; dmem_rd_data_i = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_rd = dmem_rd_en_o; s_wr = dmem_wr_en_o;
            s_addr = dmem_addr_o; s_size = dmem_wr_size_o; s_data = dmem_wr_data_o;
            if (s_rd === 1'b1) rd_log.push_back(s_addr);
            if (s_wr === 1'b1) begin wr_cnt++; last_wr_size = s_size; end
            if (s_rst === 1'b0) begin
                n_cmp++;
                if ((s_rd && s_wr) || ((s_rd || s_wr) && dmem_busy_i)) begin
                    n_fail++;
                    $display("FAIL proto: rd_en=%b wr_en=%b busy=%b", s_rd, s_wr, dmem_busy_i);
                end
            end
            @(posedge clk); #1;
            dmem_rdy_i = 0;
            if (s_rst !== 1'b0) begin
                bcnt = 0; dmem_busy_i = 0; fb_cnt = 0;
            end else if (s_rd) begin
                dmem_busy_i = 1; bcnt = 1; op_rd = 1; op_addr = s_addr;
            end else if (s_wr) begin
                dmem_busy_i = 1; bcnt = int'(s_size) + 1; op_rd = 0;
                op_addr = s_addr; op_size = s_size; op_data = s_data;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    dmem_busy_i = 0; dmem_rdy_i = 1;
                    if (op_rd) begin
                        dmem_rd_data_i = {$urandom, $urandom};
                        dmem_rd_data_i[7:0] = mem.exists(op_addr) ? mem[op_addr] : 8'h00;
                    end else begin
                        for (int i = 0; i <= int'(op_size); i++)
                            mem[op_addr + 64'(i)] = op_data[8*i +: 8];
                    end
                end
            end else begin
                dmem_busy_i = (fb_cnt > 0);
                if (fb_cnt > 0) fb_cnt--;
            end
        end
    end

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input int n, input logic sgn);
        logic [63:0] v = 0;
        for (int i = 0; i < n; i++) begin
            logic [63:0] a = addr + 64'(i);
            v = v + ((ref_mem.exists(a) ? 64'(ref_mem[a]) : 64'd0) << (8 * i));
        end
        if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    // Reference: latency from the per-byte / per-store cycle rules, data from a byte array.
    task automatic ref_predict(input logic we, input logic [63:0] addr, input logic [1:0] sz,
                               input logic sgn, input logic [63:0] wd, input int fb,
                               output logic [63:0] rdata, output int lat, output logic err);
        int n = 1 << sz;
        if (TRAP && (addr % 64'(n)) != 0) begin
            rdata = 0; lat = 1; err = 1;
        end else begin
            err = 0;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wd[8*i +: 8];
                rdata = 0; lat = n + 3 + fb;
            end else begin
                rdata = ref_load(addr, n, sgn); lat = 3 * n + 1 + fb;
            end
        end
    endtask

    task automatic check_req(input string nm, input logic we, input logic [63:0] addr,
                             input logic [1:0] sz, input logic sgn, input logic [63:0] wd,
                             input int fb, input logic [63:0] exp_rdata, input int exp_lat,
                             input logic exp_err);
        int          cyc, n, exp_rd, exp_wr;
        logic [63:0] got_rdata;
        logic        got_err, addr_ok;
        n = 1 << sz;
        @(posedge clk); #2;
        chk({nm, " ready"}, 64'(req_ready_o), 64'd1);
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_size_i = sz;
        req_signed_i = sgn; req_wdata_i = wd; fb_cnt = fb;
        rd_log.delete(); wr_cnt = 0;
        @(posedge clk); #2;
        req_valid_i = 0;
        cyc = 1;
        while (resp_valid_o !== 1'b1 && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        got_rdata = resp_rdata_o; got_err = resp_err_o;
        chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({nm, " rdata"}, got_rdata, exp_rdata);
        chk({nm, " err"}, 64'(got_err), 64'(exp_err));
        exp_rd = (exp_err || we) ? 0 : n;
        exp_wr = (!exp_err && we) ? 1 : 0;
        chk({nm, " rd_count"}, 64'(rd_log.size()), 64'(exp_rd));
        addr_ok = 1;
        foreach (rd_log[i]) if (rd_log[i] !== addr + 64'(i)) addr_ok = 0;
        chk({nm, " rd_addrs"}, 64'(addr_ok), 64'd1);
        chk({nm, " wr_count"}, 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr == 1) chk({nm, " wr_size"}, 64'(last_wr_size), 64'(n - 1));
        @(posedge clk); #2;
        chk({nm, " after_resp"}, {62'd0, resp_valid_o, req_ready_o}, 64'd1);
        chk({nm, " rdata_held"}, resp_rdata_o, exp_rdata);
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [63:0] addr;
        logic [1:0]  sz;
        logic        sgn;
        logic [63:0] wd;
        int          fb;
        logic [63:0] exp_rdata;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t tv[14];

    initial begin
        logic [63:0] r_rdata;
        int          r_lat;
        logic        r_err;
        tv[0]  = '{"st_b",    1, 64'h10, 0, 0, 64'hA5, 0, 0, 4, 0};
        tv[1]  = '{"ld_bu",   0, 64'h10, 0, 0, 0, 0, 64'hA5, 4, 0};
        tv[2]  = '{"st_d",    1, 64'h20, 3, 0, 64'h0123456789ABCDEF, 0, 0, 11, 0};
        tv[3]  = '{"ld_d",    0, 64'h20, 3, 0, 0, 0, 64'h0123456789ABCDEF, 25, 0};
        tv[4]  = '{"st_h",    1, 64'h40, 1, 0, 64'h8001, 0, 0, 5, 0};
        tv[5]  = '{"ld_hs",   0, 64'h40, 1, 1, 0, 0, 64'hFFFFFFFFFFFF8001, 7, 0};
        tv[6]  = '{"ld_hu",   0, 64'h40, 1, 0, 0, 0, 64'h8001, 7, 0};
        tv[7]  = '{"ld_bp",   0, 64'h10, 0, 0, 0, 5, 64'hA5, 9, 0};
        tv[8]  = TRAP ? '{"ld_w42", 0, 64'h42, 2, 0, 0, 0, 0, 1, 1}
                      : '{"ld_w42", 0, 64'h42, 2, 0, 0, 0, 0, 13, 0};
        tv[9]  = TRAP ? '{"st_wrap", 1, 64'hFFFFFFFFFFFFFFFE, 2, 0, 64'hDEADBEEF, 0, 0, 1, 1}
                      : '{"st_wrap", 1, 64'hFFFFFFFFFFFFFFFE, 2, 0, 64'hDEADBEEF, 0, 0, 7, 0};
        tv[10] = TRAP ? '{"ld_wrap", 0, 64'hFFFFFFFFFFFFFFFE, 2, 0, 0, 0, 0, 1, 1}
                      : '{"ld_wrap", 0, 64'hFFFFFFFFFFFFFFFE, 2, 0, 0, 0, 64'hDEADBEEF, 13, 0};
        tv[11] = '{"ld_bs",   0, 64'h23, 0, 1, 0, 0, 64'hFFFFFFFFFFFFFF89, 4, 0};
        tv[12] = '{"st_d_bp", 1, 64'h30, 3, 0, 64'h8877665544332211, 2, 0, 13, 0};
        tv[13] = '{"ld_ws",   0, 64'h34, 2, 1, 0, 0, 64'hFFFFFFFF88776655, 13, 0};

        rst = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_size_i = 0;
        req_signed_i = 0; req_wdata_i = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset ready", 64'(req_ready_o), 64'd0);
        chk("reset resp", {61'd0, resp_valid_o, resp_err_o, dmem_rd_en_o | dmem_wr_en_o}, 64'd0);
        chk("reset rdata", resp_rdata_o, 64'd0);
        rst = 0;
        @(posedge clk); #2;
        chk("post_reset ready", 64'(req_ready_o), 64'd1);

        foreach (tv[i]) begin
            ref_predict(tv[i].we, tv[i].addr, tv[i].sz, tv[i].sgn, tv[i].wd, tv[i].fb,
                        r_rdata, r_lat, r_err);
            check_req(tv[i].nm, tv[i].we, tv[i].addr, tv[i].sz, tv[i].sgn, tv[i].wd, tv[i].fb,
                      tv[i].exp_rdata, tv[i].exp_lat, tv[i].exp_err);
        end

        // Reset while a dword load sits in WAIT_RD.
        @(posedge clk); #2;
        req_valid_i = 1; req_we_i = 0; req_addr_i = 64'h20; req_size_i = 3; req_signed_i = 0;
        @(posedge clk); #2;
        req_valid_i = 0;
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;
        chk("rst_mid ctrl", {59'd0, req_ready_o, resp_valid_o, resp_err_o, dmem_rd_en_o,
                             dmem_wr_en_o}, 64'd0);
        chk("rst_mid rdata", resp_rdata_o, 64'd0);
        chk("rst_mid addr", dmem_addr_o | dmem_wr_data_o | 64'(dmem_wr_size_o), 64'd0);
        rst = 0;
        @(posedge clk); #2;
        chk("rst_mid ready", 64'(req_ready_o), 64'd1);
        check_req("after_rst", 0, 64'h10, 0, 0, 0, 0, 64'hA5, 4, 0);

        for (int k = 0; k < 40; k++) begin
            logic        we, sgn;
            logic [63:0] addr, wd;
            logic [1:0]  sz;
            int          fb;
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = 64'h100 + 64'($urandom_range(0, 63));
            wd   = {$urandom, $urandom};
            fb   = $urandom_range(0, 3);
            ref_predict(we, addr, sz, sgn, wd, fb, r_rdata, r_lat, r_err);
            check_req($sformatf("rnd%0d", k), we, addr, sz, sgn, wd, fb, r_rdata, r_lat, r_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator sitting between the execute stage and the data-memory port of the behavioural memory model. Accepts one load or store at a time from the pipeline through a valid/ready handshake. Drives the memory's rd_en/wr_en/busy/rdy protocol: loads as byte-serial reads, stores as a single sized write. Assembles load bytes little-endian, applies sign or zero extension, and returns one response pulse per request.

## Interface
- DATA_WIDTH, 64, address width.
- FETCH_WIDTH, 64, data width; must be 64. SW = $clog2(FETCH_WIDTH/8).
- Reset is rst: synchronous, active-high. Clock is clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE and not in reset.
- req_we_i  in  1  1=store, 0=load.
- req_addr_i  in  DATA_WIDTH  byte address.
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=dword; N = 1<<req_size_i bytes.
- req_signed_i  in  1  loads only: sign-extend.
- req_wdata_i  in  FETCH_WIDTH  store data; byte k in bits [8k+7:8k].
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  FETCH_WIDTH  load result; 0 for stores.
- resp_err_o  out  1  misaligned trap, see Configuration.
- dmem_rd_en_o  out  1  single-byte read request.
- dmem_wr_en_o  out  1  write request.
- dmem_addr_o  out  DATA_WIDTH  request address.
- dmem_wr_size_o  out  SW  store byte count minus 1.
- dmem_wr_data_o  out  FETCH_WIDTH  store data, little-endian.
- dmem_busy_i  in  1  memory not idle.
- dmem_rdy_i  in  1  memory transaction complete; read byte valid.
- dmem_rd_data_i  in  FETCH_WIDTH  only bits [7:0] are used.

## Operation
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, RESP.
- IDLE:
  - On req_valid_i && req_ready_o, capture addr, size, signed and wdata.
  - Clear the byte index and assembly register.
  - Go to ISSUE_WR if we=1, else ISSUE_RD.
- ISSUE_RD:
  - dmem_rd_en_o = !dmem_busy_i, dmem_addr_o = base + idx.
  - If !dmem_busy_i, go to WAIT_RD; otherwise hold.
- WAIT_RD:
  - On dmem_rdy_i, write dmem_rd_data_i[7:0] into assembly byte idx.
  - If idx == N-1, go to RESP; otherwise idx++ and go to ISSUE_RD.
- ISSUE_WR:
  - dmem_wr_en_o = !dmem_busy_i, dmem_addr_o = base, dmem_wr_size_o = N-1, dmem_wr_data_o = captured wdata, unmasked.
  - If !dmem_busy_i, go to WAIT_WR.
- WAIT_WR: on dmem_rdy_i, go to RESP.
- RESP:
  - resp_valid_o = 1.
  - Loads: resp_rdata_o = assembly register, bits ≥ 8N filled with bit 8N-1 if signed, else 0.
  - Go to IDLE.
- Address arithmetic is modulo 2^DATA_WIDTH; base + idx wraps past all-ones to 0.
- dmem_rdy_i outside WAIT_* states is ignored.
- Never assert rd_en and wr_en together.
- Never assert either request while dmem_busy_i is high.
- resp_rdata_o and resp_err_o are registered and held until the next RESP.
- Reset mid-operation: return to IDLE and abandon the transaction. The memory shares rst, so no request stays outstanding.
- Reset values: state IDLE; all outputs 0, including req_ready_o while rst is high.

## Timing
- Cycle 0 is the acceptance cycle. Memory is assumed idle: busy rises the cycle after issue, rdy lasts 1 cycle, then memory is idle.
- Load, per byte: ISSUE (rd_en high) → busy cycle → rdy/capture. That is 3 cycles per byte.
  - Load of N bytes: resp_valid_o in cycle 3N+1 (byte: 4, dword: 25).
- Store: ISSUE in cycle 1, N write-busy cycles, rdy in cycle N+2, resp_valid_o in cycle N+3 (byte: 4, dword: 11).
- req_ready_o is high again in the cycle after RESP. Maximum throughput is one request per response+1.
- All dmem_* request outputs are combinational from state and dmem_busy_i. Address and data come from registers.

## Configuration
- DMEM_LSU_MISALIGN_TRAP_EN defined:
  - A request with base % N != 0 goes from IDLE directly to RESP.
  - resp_err_o=1 and resp_rdata_o=0.
  - resp_valid_o in cycle 1, with no dmem request.
- Undefined:
  - Misaligned accesses proceed normally (byte-serial loads, sized writes).
  - resp_err_o is constant 0.

## Test plan
- Byte store 0xA5 to 0x10, then unsigned byte load from 0x10:
  - Store: one wr_en, wr_size=0, resp in cycle 4.
  - Load: resp_rdata=0x00000000000000A5, resp in cycle 4.
- Dword store 0x0123456789ABCDEF to 0x20, then load:
  - Store: wr_size=7, resp in cycle 11.
  - Load: 8 rd_en pulses at addresses 0x20–0x27, resp in cycle 25, data equal to the stored value.
- Half store 0x8001 to 0x40, then loads:
  - Signed half load → 0xFFFFFFFFFFFF8001.
  - Unsigned half load → 0x0000000000008001.
- Back-pressure: hold dmem_busy_i=1 for 5 cycles during ISSUE_RD.
  - No rd_en until busy falls; req_ready_o stays 0.
  - Response delayed by exactly 5 cycles.
- Word load at 0x42:
  - Macro off: reads at 0x42–0x45, resp_err=0.
  - Macro on: resp_valid and resp_err=1 in cycle 1, no rd_en.
- rst pulse while in WAIT_RD:
  - All outputs are 0 the next cycle.
  - req_ready_o=1 the first cycle after rst falls.
  - A new request then completes normally.
